// File: rtl/seed_fill_if.sv
// Row-write bus between the seed-fill sequencer and the board RAM write port.
//   wr_valid  master->slave  row write request, held until accepted
//   wr_ready  slave->master  RAM accepts the row on an edge where valid & ready
//   wr_row    master->slave  row address of the pending write
//   wr_data   master->slave  row bits, MSB = first bit collected
interface seed_fill_if #(
  parameter int COLS  = 32,
  parameter int ROW_W = 5
);
  logic             wr_valid;
  logic             wr_ready;
  logic [ROW_W-1:0] wr_row;
  logic [COLS-1:0]  wr_data;

  modport master (output wr_valid, output wr_row, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_row, input wr_data, output wr_ready);
endinterface

// File: rtl/seed_fill_ctrl.sv
// seed_fill_ctrl
// Drives the random_gen LFSR to seed the Game-of-Life board. After start it
// runs WARM flush cycles (bits discarded), then shifts COLS bits into a row
// register, writes that row over the valid/ready bus and repeats for ROWS
// rows, finishing with a one-cycle done pulse. abort drops back to IDLE.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         1-cycle request to begin a fill (IDLE only)
//   abort         level, returns to IDLE without done
//   random_en     LFSR advance enable (high only in WARMUP/SHIFT)
//   random_data   LFSR output bit
//   wr            row write bus (master side)
//   busy          high whenever not IDLE
//   done          1-cycle pulse after last row accepted
module seed_fill_ctrl #(
  parameter int ROWS  = 32,
  parameter int COLS  = 32,
  parameter int ROW_W = 5,
  parameter int WARM  = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  output logic         random_en,
  input  logic         random_data,
  seed_fill_if.master  wr,
  output logic         busy,
  output logic         done
);

  localparam int CNT_MAX = (WARM > COLS) ? WARM : COLS;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  // WARM == 0 never enters WARMUP, so its terminal value is unused then.
  localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'((WARM > 0) ? (WARM - 1) : 0);
  localparam logic [CNT_W-1:0] COLS_LAST = CNT_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WARMUP,
    S_SHIFT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COLS-1:0]  data_q, data_d;
  logic             random_en_q, random_en_d;
  logic             wr_valid_q, wr_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    data_d  = data_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          row_d   = '0;
          cnt_d   = '0;
          state_d = (WARM > 0) ? S_WARMUP : S_SHIFT;
        end
      end
      S_WARMUP: begin
        if (cnt_q == WARM_LAST) begin
          cnt_d   = '0;
          state_d = S_SHIFT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SHIFT: begin
        // First bit collected ends up in the MSB after COLS shifts.
        data_d = {data_q[COLS-2:0], random_data};
        if (cnt_q == COLS_LAST) begin
          cnt_d   = '0;
          state_d = S_WRITE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WRITE: begin
        if (wr.wr_ready) begin
          if (row_q == ROW_LAST) begin
            state_d = S_DONE;
          end else begin
            row_d   = row_q + 1'b1;
            cnt_d   = '0;
            state_d = S_SHIFT;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // abort wins over wr_ready and start: any pending row is dropped.
    if (abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      row_d   = '0;
      data_d  = '0;
    end

    // Moore outputs registered from the next state so they line up with it.
    random_en_d = (state_d == S_WARMUP) || (state_d == S_SHIFT);
    wr_valid_d  = (state_d == S_WRITE);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      row_q       <= '0;
      data_q      <= '0;
      random_en_q <= 1'b0;
      wr_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      row_q       <= row_d;
      data_q      <= data_d;
      random_en_q <= random_en_d;
      wr_valid_q  <= wr_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign random_en   = random_en_q;
  assign wr.wr_valid = wr_valid_q;
  assign wr.wr_row   = row_q;
  assign wr.wr_data  = data_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_seed_fill_ctrl.sv
module tb_seed_fill_ctrl;

  localparam int ROWS  = 4;
  localparam int COLS  = 8;
  localparam int ROW_W = 2;
  localparam int WARM  = 2;
  localparam int SLEN  = 2048;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic start_a = 1'b0, abort_a = 1'b0, ready_a = 1'b1;
  logic start_b = 1'b0, abort_b = 1'b0, ready_b = 1'b1;
  logic en_a, en_b, busy_a, busy_b, done_a, done_b;
  logic rd_a, rd_b;

  // Random bit streams stand in for random_gen: one bit consumed per enabled edge.
  bit stream_a [SLEN];
  bit stream_b [SLEN];
  int ptr_a = 0, ptr_b = 0;
  assign rd_a = stream_a[ptr_a];
  assign rd_b = stream_b[ptr_b];
  always @(posedge clk) if (en_a) ptr_a <= ptr_a + 1;
  always @(posedge clk) if (en_b) ptr_b <= ptr_b + 1;

  seed_fill_if #(.COLS(COLS), .ROW_W(ROW_W)) ifa ();
  seed_fill_if #(.COLS(COLS), .ROW_W(ROW_W)) ifb ();
  assign ifa.wr_ready = ready_a;
  assign ifb.wr_ready = ready_b;

  seed_fill_ctrl #(.ROWS(ROWS), .COLS(COLS), .ROW_W(ROW_W), .WARM(WARM)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
    .random_en(en_a), .random_data(rd_a), .wr(ifa), .busy(busy_a), .done(done_a));

  seed_fill_ctrl #(.ROWS(ROWS), .COLS(COLS), .ROW_W(ROW_W), .WARM(0)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
    .random_en(en_b), .random_data(rd_b), .wr(ifb), .busy(busy_b), .done(done_b));

  typedef struct {
    int         row;
    logic [7:0] data;
  } wr_t;

  wr_t wq_a[$];
  wr_t wq_b[$];
  int  en_cnt_a = 0, done_cnt_a = 0, done_cnt_b = 0;

  // Observe the bus mid-cycle, where inputs and outputs are settled for the next edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (ifa.wr_valid && ready_a && !abort_a) wq_a.push_back('{int'(ifa.wr_row), ifa.wr_data});
      if (ifb.wr_valid && ready_b && !abort_b) wq_b.push_back('{int'(ifb.wr_row), ifb.wr_data});
      if (en_a)   en_cnt_a++;
      if (done_a) done_cnt_a++;
      if (done_b) done_cnt_b++;
    end
  end

  int n_total = 0, n_pass = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Row r of a fill starting at stream offset base: skip warm bits, MSB first.
  function automatic logic [7:0] exp_row(input bit sel_b, input int base, input int warm, input int r);
    logic [7:0] d = '0;
    for (int k = 0; k < COLS; k++)
      d[COLS-1-k] = sel_b ? stream_b[base + warm + r*COLS + k] : stream_a[base + warm + r*COLS + k];
    return d;
  endfunction

  typedef struct {
    int stall_row;   // -1: never hold wr_ready low
    int stall_len;
    int abort_row;   // -1: no abort; else abort in first SHIFT cycle of that row
    bit spam;        // pulse start while busy
    int exp_writes;
    int exp_done;
    int exp_cycles;  // start edge to done visible, -1 when aborted
    int exp_en;
  } vec_t;

  vec_t vecs[$];

  task automatic run_fill(input int idx, input vec_t v);
    int  base = ptr_a;
    int  q0 = wq_a.size();
    int  en0 = en_cnt_a;
    int  d0 = done_cnt_a;
    int  cyc = 0;
    int  stall_cnt = 0;
    bit  got_done = 0, aborted = 0, stable_ok = 1;
    logic [7:0] hold = '0;
    int  nw;
    string tag = $sformatf("v%0d", idx);

    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    cyc = 1;
    while (!got_done && !aborted && cyc < 300) begin
      ready_a = 1'b1;
      abort_a = 1'b0;
      if (ifa.wr_valid && int'(ifa.wr_row) == v.stall_row) begin
        if (stall_cnt == 0) hold = ifa.wr_data;
        else if (ifa.wr_data != hold || en_a) stable_ok = 0;
        if (stall_cnt < v.stall_len) begin
          ready_a = 1'b0;
          stall_cnt++;
        end
      end
      if (v.abort_row >= 0 && int'(ifa.wr_row) == v.abort_row && en_a) abort_a = 1'b1;
      start_a = v.spam && (en_a || ifa.wr_valid);
      tick();
      cyc++;
      if (abort_a) begin
        aborted = 1;
        abort_a = 1'b0;
        check({tag, "_abort_busy"},  busy_a, 0);
        check({tag, "_abort_en"},    en_a, 0);
        check({tag, "_abort_valid"}, ifa.wr_valid, 0);
        check({tag, "_abort_done"},  done_a, 0);
        check({tag, "_abort_row"},   ifa.wr_row, 0);
      end
      if (done_a) got_done = 1;
    end
    start_a = 1'b0;
    ready_a = 1'b1;
    if (!got_done && !aborted) check({tag, "_timeout"}, 0, 1);
    if (v.exp_cycles >= 0) check({tag, "_latency"}, cyc, v.exp_cycles);
    if (v.stall_len > 0) check({tag, "_stall_stable"}, stable_ok, 1);
    repeat (3) tick();
    check({tag, "_en_count"}, en_cnt_a - en0, v.exp_en);
    check({tag, "_done_count"}, done_cnt_a - d0, v.exp_done);
    nw = wq_a.size() - q0;
    check({tag, "_writes"}, nw, v.exp_writes);
    for (int i = 0; i < nw && i < v.exp_writes; i++) begin
      check($sformatf("%s_row%0d_addr", tag, i), wq_a[q0+i].row, i);
      check($sformatf("%s_row%0d_data", tag, i), wq_a[q0+i].data, exp_row(0, base, WARM, i));
    end
  endtask

  initial begin
    int base, q0, cyc, n;

    for (int i = 0; i < SLEN; i++) begin
      stream_a[i] = bit'($urandom_range(0, 1));
      stream_b[i] = bit'($urandom_range(0, 1));
    end

    // Reset held with start asserted.
    rst = 1'b1; start_a = 1'b1; start_b = 1'b1;
    repeat (3) tick();
    check("rst_en",    en_a, 0);
    check("rst_valid", ifa.wr_valid, 0);
    check("rst_row",   ifa.wr_row, 0);
    check("rst_data",  ifa.wr_data, 0);
    check("rst_busy",  busy_a, 0);
    check("rst_done",  done_a, 0);
    check("rst_b_busy", busy_b, 0);
    check("rst_b_en",   en_b, 0);
    start_a = 1'b0; start_b = 1'b0;
    rst = 1'b0;
    tick();
    check("idle_busy", busy_a, 0);

    // Directed scenarios, then randomized backpressure/start-spam fills.
    vecs.push_back('{-1, 0, -1, 0, 4, 1, 39, 34});
    vecs.push_back('{ 1, 5, -1, 0, 4, 1, 44, 34});
    vecs.push_back('{-1, 0,  2, 0, 2, 0, -1, 19});
    vecs.push_back('{-1, 0, -1, 0, 4, 1, 39, 34});
    vecs.push_back('{-1, 0, -1, 1, 4, 1, 39, 34});
    for (int i = 0; i < 6; i++) begin
      vec_t r;
      r.stall_row  = $urandom_range(0, ROWS - 1);
      r.stall_len  = $urandom_range(0, 6);
      r.abort_row  = -1;
      r.spam       = bit'($urandom_range(0, 1));
      r.exp_writes = ROWS;
      r.exp_done   = 1;
      r.exp_cycles = 1 + WARM + ROWS*(COLS+1) + r.stall_len;
      r.exp_en     = WARM + ROWS*COLS;
      vecs.push_back(r);
    end
    for (int i = 0; i < vecs.size(); i++) run_fill(i, vecs[i]);

    // Reset in the middle of a stalled write: row discarded, back to idle.
    q0 = wq_a.size();
    n = done_cnt_a;
    ready_a = 1'b0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (13) tick();
    check("midrst_in_write", ifa.wr_valid, 1);
    check("midrst_row0",     ifa.wr_row, 0);
    rst = 1'b1;
    ready_a = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_valid", ifa.wr_valid, 0);
    check("midrst_busy",  busy_a, 0);
    check("midrst_data",  ifa.wr_data, 0);
    repeat (3) tick();
    check("midrst_writes", wq_a.size() - q0, 0);
    check("midrst_done",   done_cnt_a - n, 0);

    // WARM = 0: shifting starts on the edge after start.
    base = ptr_b;
    q0 = wq_b.size();
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    check("w0_en_first", en_b, 1);
    check("w0_busy",     busy_b, 1);
    cyc = 1;
    while (!done_b && cyc < 300) begin
      tick();
      cyc++;
    end
    check("w0_latency", cyc, 1 + ROWS*(COLS+1));
    repeat (2) tick();
    n = wq_b.size() - q0;
    check("w0_writes", n, ROWS);
    check("w0_done_count", done_cnt_b, 1);
    for (int i = 0; i < n && i < ROWS; i++)
      check($sformatf("w0_row%0d_data", i), wq_b[q0+i].data, exp_row(1, base, 0, i));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
